// File: rtl/fifo_out_arbiter.sv
// fifo_out_arbiter: round-robin arbiter that drains two first-word-fall-through
// FIFOs, one byte at a time, into a single output device. The device is driven
// through an out_start / out_finish handshake.
//
// Optional feature: define FIFO_ARB_BURST_EN to let a channel keep the grant
// for up to BURST_LEN consecutive bytes. Without it, the arbiter strictly
// alternates when both channels are eligible.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   enable                   permits new grants (a byte in flight always completes)
//   fifoN_empty/busy/data    FIFO N status and head word (N = 0, 1)
//   fifoN_re                 one-cycle pop strobe to FIFO N
//   out_finish               output device ready/done (high = ready)
//   out_data                 byte presented to the device, held until the next pop
//   out_start                request to the device
//   grant                    one-hot owning channel, 00 when idle
//   idle                     high only in IDLE
module fifo_out_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo0_empty,
    input  logic              fifo0_busy,
    input  logic [DATA_W-1:0] fifo0_data,
    output logic              fifo0_re,
    input  logic              fifo1_empty,
    input  logic              fifo1_busy,
    input  logic [DATA_W-1:0] fifo1_data,
    output logic              fifo1_re,
    input  logic              out_finish,
    output logic [DATA_W-1:0] out_data,
    output logic              out_start,
    output logic [1:0]        grant,
    output logic              idle
);

    localparam int unsigned CNT_W = 4;

    // Reject burst lengths the 4-bit counter cannot represent.
    if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
        $error("fifo_out_arbiter: BURST_LEN must be 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_fifo0_re;
    logic                r_fifo1_re;
    logic                r_out_start;
    logic [DATA_W-1:0]   r_out_data;
    logic [1:0]          r_grant;
    logic                r_idle;

    state_t              w_state_nxt;
    logic                w_last_nxt;
    logic                w_fifo0_re_nxt;
    logic                w_fifo1_re_nxt;
    logic                w_out_start_nxt;
    logic [DATA_W-1:0]   w_out_data_nxt;
    logic [1:0]          w_grant_nxt;
    logic                w_idle_nxt;

    logic                w_elig0;
    logic                w_elig1;
    logic                w_win;

    assign w_elig0 = !fifo0_empty && !fifo0_busy;
    assign w_elig1 = !fifo1_empty && !fifo1_busy;

`ifdef FIFO_ARB_BURST_EN
    logic [CNT_W-1:0]    r_burst_cnt;
    logic [CNT_W-1:0]    w_burst_cnt_nxt;
    logic                w_burst_hold;

    // A count of zero means no burst is running yet (after reset), so plain
    // alternation decides the first contested grant.
    assign w_burst_hold = (r_burst_cnt != '0) && (r_burst_cnt < CNT_W'(BURST_LEN));

    // Winner: the sole eligible channel, otherwise the previous owner while its
    // burst is unfinished, otherwise the channel that did not go last.
    always_comb begin
        w_win = w_elig1;
        if (w_elig0 && w_elig1) begin
            w_win = w_burst_hold ? r_last : ~r_last;
        end
    end
`else
    // Winner: the sole eligible channel, otherwise the channel that did not go last.
    always_comb begin
        w_win = w_elig1;
        if (w_elig0 && w_elig1) begin
            w_win = ~r_last;
        end
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_fifo0_re_nxt  = 1'b0;
        w_fifo1_re_nxt  = 1'b0;
        w_out_start_nxt = r_out_start;
        w_out_data_nxt  = r_out_data;
        w_grant_nxt     = r_grant;
`ifdef FIFO_ARB_BURST_EN
        w_burst_cnt_nxt = r_burst_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (enable && out_finish && (w_elig0 || w_elig1)) begin
                    w_fifo0_re_nxt = ~w_win;
                    w_fifo1_re_nxt = w_win;
                    w_out_data_nxt = w_win ? fifo1_data : fifo0_data;
                    w_grant_nxt    = {w_win, ~w_win};
                    w_state_nxt    = S_POP;
`ifdef FIFO_ARB_BURST_EN
                    // Continuing owner counts up (wrapping to 1 at the limit);
                    // a change of owner restarts the count at this pop.
                    if ((w_win == r_last) && (r_burst_cnt != '0)
                        && (r_burst_cnt < CNT_W'(BURST_LEN))) begin
                        w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
                    end else begin
                        w_burst_cnt_nxt = CNT_W'(1);
                    end
`endif
                end
            end
            S_POP: begin
                w_out_start_nxt = 1'b1;
                w_state_nxt     = S_ACK;
            end
            S_ACK: begin
                // Device signals acceptance by dropping out_finish.
                if (!out_finish) begin
                    w_out_start_nxt = 1'b0;
                    w_state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_finish) begin
                    w_last_nxt  = r_grant[1];
                    w_grant_nxt = 2'b00;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_idle_nxt = (w_state_nxt == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_fifo0_re  <= 1'b0;
            r_fifo1_re  <= 1'b0;
            r_out_start <= 1'b0;
            r_out_data  <= '0;
            r_grant     <= 2'b00;
            r_idle      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_fifo0_re  <= w_fifo0_re_nxt;
            r_fifo1_re  <= w_fifo1_re_nxt;
            r_out_start <= w_out_start_nxt;
            r_out_data  <= w_out_data_nxt;
            r_grant     <= w_grant_nxt;
            r_idle      <= w_idle_nxt;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    // Burst counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end
`endif

    assign fifo0_re  = r_fifo0_re;
    assign fifo1_re  = r_fifo1_re;
    assign out_start = r_out_start;
    assign out_data  = r_out_data;
    assign grant     = r_grant;
    assign idle      = r_idle;

endmodule

// File: tb/tb_fifo_out_arbiter.sv
// Directed testbench for fifo_out_arbiter: FWFT FIFO models, an auto-handshaking
// output device and hand-computed expected byte orders.
module tb_fifo_out_arbiter;

    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              fifo0_empty, fifo0_busy, fifo0_re;
    logic              fifo1_empty, fifo1_busy, fifo1_re;
    logic [DATA_W-1:0] fifo0_data, fifo1_data;
    logic              out_finish;
    logic [DATA_W-1:0] out_data;
    logic              out_start;
    logic [1:0]        grant;
    logic              idle;

    fifo_out_arbiter #(.DATA_W(DATA_W), .BURST_LEN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo0_empty (fifo0_empty),
        .fifo0_busy  (fifo0_busy),
        .fifo0_data  (fifo0_data),
        .fifo0_re    (fifo0_re),
        .fifo1_empty (fifo1_empty),
        .fifo1_busy  (fifo1_busy),
        .fifo1_data  (fifo1_data),
        .fifo1_re    (fifo1_re),
        .out_finish  (out_finish),
        .out_data    (out_data),
        .out_start   (out_start),
        .grant       (grant),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FIFO models
    logic [DATA_W-1:0] mem0 [16];
    logic [DATA_W-1:0] mem1 [16];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic [3:0] ri0, ri1;
    assign ri0 = rp0[3:0];
    assign ri1 = rp1[3:0];
    assign fifo0_empty = (rp0 == wp0);
    assign fifo1_empty = (rp1 == wp1);
    assign fifo0_data  = mem0[ri0];
    assign fifo1_data  = mem1[ri1];

    logic [DATA_W-1:0] out_log [32];
    int nlog = 0;
    int both_re = 0;
    int bad_grant = 0;
    bit dev_auto = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic [DATA_W-1:0] d);
        mem0[wp0 % 16] = d;
        wp0++;
    endtask

    task automatic push1(input logic [DATA_W-1:0] d);
        mem1[wp1 % 16] = d;
        wp1++;
    endtask

    // Pop on strobe, log popped bytes, watch invariants, model the device.
    always @(negedge clk) begin
        if (fifo0_re) rp0++;
        if (fifo1_re) rp1++;
        if (fifo0_re || fifo1_re) begin
            out_log[nlog % 32] = out_data;
            nlog++;
        end
        if (fifo0_re && fifo1_re) both_re++;
        if (grant == 2'b11) bad_grant++;
        if (dev_auto) begin
            if (out_start && out_finish)        out_finish = 1'b0;
            else if (!out_start && !out_finish) out_finish = 1'b1;
        end
    end

    // Wait until idle with no serviceable data left; bounded.
    task automatic wait_drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (idle && (rp0 == wp0) && (fifo1_busy || rp1 == wp1)) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        fifo0_busy = 1'b0;
        fifo1_busy = 1'b0;
        out_finish = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_re0",   32'(fifo0_re), 32'd0);
        check_eq("rst_re1",   32'(fifo1_re), 32'd0);
        check_eq("rst_start", 32'(out_start), 32'd0);
        check_eq("rst_data",  32'(out_data), 32'd0);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_idle",  32'(idle), 32'd1);

        // Single byte: pop next edge, out_start one edge later
        rst_n  = 1'b1;
        enable = 1'b1;
        push0(8'hA5);
        @(posedge clk); #1;
        check_eq("t1_re0",    32'(fifo0_re), 32'd1);
        check_eq("t1_re1",    32'(fifo1_re), 32'd0);
        check_eq("t1_data",   32'(out_data), 32'hA5);
        check_eq("t1_grant",  32'(grant), 32'b01);
        check_eq("t1_idle0",  32'(idle), 32'd0);
        check_eq("t1_start0", 32'(out_start), 32'd0);
        @(posedge clk); #1;
        check_eq("t1_re0_off", 32'(fifo0_re), 32'd0);
        check_eq("t1_start1",  32'(out_start), 32'd1);
        wait_drain("t1_drain");
        check_eq("t1_idle1",  32'(idle), 32'd1);
        check_eq("t1_grant0", 32'(grant), 32'b00);
        check_eq("t1_start_off", 32'(out_start), 32'd0);

        // Both FIFOs loaded after a fresh reset
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        nlog = 0;
        push0(8'h10); push0(8'h11); push0(8'h12);
        push1(8'h20); push1(8'h21); push1(8'h22);
        wait_drain("t2_drain");
        check_eq("t2_count", 32'(nlog), 32'd6);
`ifdef FIFO_ARB_BURST_EN
        check_eq("t2_b0", 32'(out_log[0]), 32'h10);
        check_eq("t2_b1", 32'(out_log[1]), 32'h11);
        check_eq("t2_b2", 32'(out_log[2]), 32'h20);
        check_eq("t2_b3", 32'(out_log[3]), 32'h21);
        check_eq("t2_b4", 32'(out_log[4]), 32'h12);
        check_eq("t2_b5", 32'(out_log[5]), 32'h22);
`else
        check_eq("t2_b0", 32'(out_log[0]), 32'h10);
        check_eq("t2_b1", 32'(out_log[1]), 32'h20);
        check_eq("t2_b2", 32'(out_log[2]), 32'h11);
        check_eq("t2_b3", 32'(out_log[3]), 32'h21);
        check_eq("t2_b4", 32'(out_log[4]), 32'h12);
        check_eq("t2_b5", 32'(out_log[5]), 32'h22);
`endif

        // enable dropped in ACK: byte completes, nothing further until re-enabled
        @(negedge clk);
        nlog = 0;
        push0(8'h30); push0(8'h31);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("t3_in_ack", 32'(out_start), 32'd1);
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("t3_count_hold", 32'(nlog), 32'd1);
        check_eq("t3_b0",         32'(out_log[0]), 32'h30);
        check_eq("t3_idle",       32'(idle), 32'd1);
        check_eq("t3_pending",    32'(fifo0_empty), 32'd0);
        @(negedge clk); enable = 1'b1;
        wait_drain("t3_drain");
        check_eq("t3_count", 32'(nlog), 32'd2);
        check_eq("t3_b1",    32'(out_log[1]), 32'h31);

        // Busy channel 1 is skipped until released
        @(negedge clk);
        nlog = 0;
        fifo1_busy = 1'b1;
        push0(8'h40); push0(8'h41);
        push1(8'h50);
        wait_drain("t4_drain0");
        check_eq("t4_count0", 32'(nlog), 32'd2);
        check_eq("t4_b0",     32'(out_log[0]), 32'h40);
        check_eq("t4_b1",     32'(out_log[1]), 32'h41);
        check_eq("t4_pend1",  32'(fifo1_empty), 32'd0);
        @(negedge clk); fifo1_busy = 1'b0;
        @(posedge clk); #1;
        check_eq("t4_grant1", 32'(grant), 32'b10);
        check_eq("t4_re1",    32'(fifo1_re), 32'd1);
        check_eq("t4_data",   32'(out_data), 32'h50);
        wait_drain("t4_drain1");

        // Reset while stalled in ACK
        @(negedge clk);
        dev_auto = 1'b0;
        push1(8'h60);
        @(posedge clk); #1;
        check_eq("t5_grant1", 32'(grant), 32'b10);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_stalled", 32'(out_start), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_start_async", 32'(out_start), 32'd0);
        check_eq("t5_grant_async", 32'(grant), 32'b00);
        check_eq("t5_re_async",    32'({fifo1_re, fifo0_re}), 32'd0);
        check_eq("t5_idle_async",  32'(idle), 32'd1);
        @(negedge clk);
        nlog = 0;
        push0(8'h62);
        push1(8'h61);
        dev_auto = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_grant0", 32'(grant), 32'b01);
        check_eq("t5_re0",    32'(fifo0_re), 32'd1);
        check_eq("t5_data",   32'(out_data), 32'h62);
        wait_drain("t5_drain");
        check_eq("t5_count", 32'(nlog), 32'd2);
        check_eq("t5_b1",    32'(out_log[1]), 32'h61);

        // Invariants over the whole run
        check_eq("never_both_re", 32'(both_re), 32'd0);
        check_eq("never_grant11", 32'(bad_grant), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
